// File: rtl/ex_complete_buffer_pkg.sv
// Shared constants and entry layout for the two-wide completion buffer.
// The ZERO_REG destination marks results that never need to reach the CDB.
package ex_complete_buffer_pkg;

  localparam int DATA_W   = 64;
  localparam int IR_W     = 32;
  localparam int REG_W    = 5;
  localparam int CB_DEPTH = 4;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [IR_W-1:0]   ir;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] result;
  } cb_entry_t;

  localparam int ENTRY_W = $bits(cb_entry_t);

  // A result is worth buffering only when it is valid and writes a real register.
  function automatic logic writes_reg(input logic valid, input logic [REG_W-1:0] dest);
    return valid && (dest != ZERO_REG);
  endfunction

endpackage

// File: rtl/ex_complete_buffer_if.sv
// Bundle of execute-side results, stall feedback and CDB broadcast signals.
// slave is the completion buffer; master is the execute stage / CDB consumer side.
interface ex_complete_buffer_if;
  import ex_complete_buffer_pkg::*;

  logic              flush;
  logic              cdb_stall;

  logic              ex_valid_out_1;
  logic [DATA_W-1:0] ex_NPC_out_1;
  logic [IR_W-1:0]   ex_IR_out_1;
  logic [REG_W-1:0]  ex_dest_reg_out_1;
  logic [DATA_W-1:0] ex_result_out_1;

  logic              ex_valid_out_2;
  logic [DATA_W-1:0] ex_NPC_out_2;
  logic [IR_W-1:0]   ex_IR_out_2;
  logic [REG_W-1:0]  ex_dest_reg_out_2;
  logic [DATA_W-1:0] ex_result_out_2;

  logic              stall_bus_1;
  logic              stall_bus_2;

  logic              cdb_valid_1;
  logic [DATA_W-1:0] cdb_NPC_1;
  logic [IR_W-1:0]   cdb_IR_1;
  logic [REG_W-1:0]  cdb_dest_reg_1;
  logic [DATA_W-1:0] cdb_result_1;

  logic              cdb_valid_2;
  logic [DATA_W-1:0] cdb_NPC_2;
  logic [IR_W-1:0]   cdb_IR_2;
  logic [REG_W-1:0]  cdb_dest_reg_2;
  logic [DATA_W-1:0] cdb_result_2;

  logic              overflow_err;

  modport slave (
    input  flush, cdb_stall,
    input  ex_valid_out_1, ex_NPC_out_1, ex_IR_out_1, ex_dest_reg_out_1, ex_result_out_1,
    input  ex_valid_out_2, ex_NPC_out_2, ex_IR_out_2, ex_dest_reg_out_2, ex_result_out_2,
    output stall_bus_1, stall_bus_2,
    output cdb_valid_1, cdb_NPC_1, cdb_IR_1, cdb_dest_reg_1, cdb_result_1,
    output cdb_valid_2, cdb_NPC_2, cdb_IR_2, cdb_dest_reg_2, cdb_result_2,
    output overflow_err
  );

  modport master (
    output flush, cdb_stall,
    output ex_valid_out_1, ex_NPC_out_1, ex_IR_out_1, ex_dest_reg_out_1, ex_result_out_1,
    output ex_valid_out_2, ex_NPC_out_2, ex_IR_out_2, ex_dest_reg_out_2, ex_result_out_2,
    input  stall_bus_1, stall_bus_2,
    input  cdb_valid_1, cdb_NPC_1, cdb_IR_1, cdb_dest_reg_1, cdb_result_1,
    input  cdb_valid_2, cdb_NPC_2, cdb_IR_2, cdb_dest_reg_2, cdb_result_2,
    input  overflow_err
  );

endinterface

// File: rtl/ex_complete_buffer_cb_fifo_2w2r.sv
// Generic circular FIFO with two write ports and two combinational read ports.
// Writer guarantees no overrun; reader guarantees rd_num never exceeds count.
module cb_fifo_2w2r #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en_1,
  input  logic [W-1:0]  wr_data_1,
  input  logic          wr_en_2,
  input  logic [W-1:0]  wr_data_2,
  input  logic [1:0]    rd_num,
  output logic [W-1:0]  rd_data_1,
  output logic [W-1:0]  rd_data_2,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] head_next;
  logic [PW-1:0] tail_next;
  logic [PW-1:0] head_1;
  logic [PW-1:0] tail_2;
  logic [1:0]    wr_num;

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] we;
  logic [W-1:0]     wd  [DEPTH];

  assign wr_num = {1'b0, wr_en_1} + {1'b0, wr_en_2};
  // Port 2 lands right behind port 1, or at tail itself when port 1 is idle.
  assign tail_2 = tail_reg + PW'(wr_en_1);
  assign head_1 = head_reg + PW'(1);

  always_comb begin
    head_next  = head_reg + PW'(rd_num);
    tail_next  = tail_reg + PW'(wr_num);
    count_next = count_reg + CW'(wr_num) - CW'(rd_num);
    if (clear) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hit_1;
      logic hit_2;
      assign hit_1   = wr_en_1 && (tail_reg == PW'(gi));
      assign hit_2   = wr_en_2 && (tail_2 == PW'(gi));
      assign we[gi]  = !clear && (hit_1 || hit_2);
      assign wd[gi]  = hit_1 ? wr_data_1 : wr_data_2;
    end
  endgenerate

  // Storage carries no reset: stale slots are never presented as valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) begin
        mem[i] <= wd[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign rd_data_1 = mem[head_reg];
  assign rd_data_2 = mem[head_1];
  assign count     = count_reg;

endmodule

// File: rtl/ex_complete_buffer.sv
// Two-wide completion buffer between ex_stage and the two-slot CDB: filters
// ZERO_REG results, drains oldest-first, and throttles ex_stage via registered stalls.
module ex_complete_buffer
  import ex_complete_buffer_pkg::*;
#(
  parameter int DEPTH = CB_DEPTH
) (
  input logic                  clock,
  input logic                  reset,
  ex_complete_buffer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  cb_entry_t     in_1;
  cb_entry_t     in_2;
  cb_entry_t     out_1;
  cb_entry_t     out_2;
  logic          acc_1;
  logic          acc_2;
  logic          drain_ok;
  logic          valid_1;
  logic          valid_2;
  logic [1:0]    rd_num;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          stall_1_reg;
  logic          stall_2_reg;
  logic          overflow_err_reg;

  assign in_1 = '{npc:    bus.ex_NPC_out_1,
                  ir:     bus.ex_IR_out_1,
                  dest:   bus.ex_dest_reg_out_1,
                  result: bus.ex_result_out_1};
  assign in_2 = '{npc:    bus.ex_NPC_out_2,
                  ir:     bus.ex_IR_out_2,
                  dest:   bus.ex_dest_reg_out_2,
                  result: bus.ex_result_out_2};

  assign acc_1 = writes_reg(bus.ex_valid_out_1, bus.ex_dest_reg_out_1) && !stall_1_reg && !bus.flush;
  assign acc_2 = writes_reg(bus.ex_valid_out_2, bus.ex_dest_reg_out_2) && !stall_2_reg && !bus.flush;

  assign drain_ok = !bus.cdb_stall && !bus.flush;

  always_comb begin
    rd_num = 2'd0;
    if (drain_ok) begin
      rd_num = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end
  end

  cb_fifo_2w2r #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (bus.flush),
    .wr_en_1    (acc_1),
    .wr_data_1  (in_1),
    .wr_en_2    (acc_2),
    .wr_data_2  (in_2),
    .rd_num     (rd_num),
    .rd_data_1  (out_1),
    .rd_data_2  (out_2),
    .count      (count),
    .count_next (count_next)
  );

  assign valid_1 = drain_ok && (count != '0);
  assign valid_2 = drain_ok && (count >= CW'(2));

  // Payloads are zeroed when idle so the bus is quiet out of reset and when empty.
  assign bus.cdb_valid_1    = valid_1;
  assign bus.cdb_NPC_1      = valid_1 ? out_1.npc    : '0;
  assign bus.cdb_IR_1       = valid_1 ? out_1.ir     : '0;
  assign bus.cdb_dest_reg_1 = valid_1 ? out_1.dest   : '0;
  assign bus.cdb_result_1   = valid_1 ? out_1.result : '0;

  assign bus.cdb_valid_2    = valid_2;
  assign bus.cdb_NPC_2      = valid_2 ? out_2.npc    : '0;
  assign bus.cdb_IR_2       = valid_2 ? out_2.ir     : '0;
  assign bus.cdb_dest_reg_2 = valid_2 ? out_2.dest   : '0;
  assign bus.cdb_result_2   = valid_2 ? out_2.result : '0;

  // Stalls ignore any drain next cycle, so a persistent cdb_stall cannot cause overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_1_reg      <= 1'b0;
      stall_2_reg      <= 1'b0;
      overflow_err_reg <= 1'b0;
    end else begin
      stall_1_reg <= count_next > CW'(DEPTH - 1);
      stall_2_reg <= count_next > CW'(DEPTH - 2);
      if ((bus.ex_valid_out_1 && stall_1_reg) || (bus.ex_valid_out_2 && stall_2_reg)) begin
        overflow_err_reg <= 1'b1;
      end
    end
  end

  assign bus.stall_bus_1  = stall_1_reg;
  assign bus.stall_bus_2  = stall_2_reg;
  assign bus.overflow_err = overflow_err_reg;

endmodule
